phy_tx_stripe_mux: RTL and testbench

PHY_TX_STRIPE_MUX -- requirements
Module: phy_tx_stripe_mux

---
 rtl/phy_tx_stripe_mux.sv | 187 ++++++++++++++++++
 tb/tb_phy_tx_stripe_mux.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_stripe_mux.sv
// phy_tx_stripe_mux: one small FIFO per lane, drained onto a single serial
// stream by a round-robin scheduler, plus a registered loopback path that
// carries lane words straight through while the transmitter is not active.
// Optional build macro: PHY_TX_SKIP_EMPTY_EN selects a work-conserving
// scheduler that skips empty lanes instead of emitting idle slots for them.
module phy_tx_stripe_mux #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     active,
  input  logic [LANES*WIDTH-1:0]   data_in,
  input  logic [LANES-1:0]         valid_in,
  output logic [LANES-1:0]         full,
  output logic [LANES-1:0]         overflow,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  output logic [$clog2(LANES)-1:0] lane_out,
  output logic [LANES*WIDTH-1:0]   recirc_data,
  output logic [LANES-1:0]         recirc_valid
);

  localparam int unsigned LaneW = $clog2(LANES);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  // Per-lane FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_q    [LANES][DEPTH];
  logic [PtrW-1:0]  wr_ptr_q [LANES];
  logic [PtrW-1:0]  rd_ptr_q [LANES];
  logic [CntW-1:0]  count_q  [LANES];
  logic [LANES-1:0] overflow_q;

  // Scheduler
  logic [0:0]       state_q, state_d;
  logic [LaneW-1:0] rr_ptr_q, rr_ptr_d;
  logic             pop_en;
  logic [LaneW-1:0] pop_lane;
  logic [LANES-1:0] pop_vec;

  // Registered stream outputs
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic [LaneW-1:0] lane_out_q, lane_out_d;

  // Loopback registers
  logic [LANES*WIDTH-1:0] recirc_data_q;
  logic [LANES-1:0]       recirc_valid_q;

  logic [LANES-1:0] empty, push, drop;

`ifdef PHY_TX_SKIP_EMPTY_EN
  logic             found;
  logic [LaneW-1:0] cand;
`endif

  function automatic logic [LaneW-1:0] lane_inc(input logic [LaneW-1:0] l);
    return (l == LaneW'(LANES - 1)) ? '0 : l + 1'b1;
  endfunction

  // FIFO status; a push is judged against fullness at the start of the cycle,
  // so a same-cycle pop never rescues a push into a full FIFO.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      empty[i] = (count_q[i] == '0);
      full[i]  = (count_q[i] == CntW'(DEPTH));
      push[i]  = active & valid_in[i] & ~full[i];
      drop[i]  = active & valid_in[i] & full[i];
    end
  end

  // Scheduler next state, pop selection and next stream output word
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    pop_en      = 1'b0;
    pop_lane    = rr_ptr_q;
    data_out_d  = '0;
    valid_out_d = 1'b0;
    lane_out_d  = '0;
`ifdef PHY_TX_SKIP_EMPTY_EN
    found = 1'b0;
    cand  = '0;
`endif
    unique case (state_q)
      StIdle: begin
        rr_ptr_d = '0;
        if (!(&empty)) state_d = StRun;
      end
      StRun: begin
`ifdef PHY_TX_SKIP_EMPTY_EN
        // First non-empty lane at or after the pointer, wrapping
        for (int unsigned k = 0; k < LANES; k++) begin
          cand = LaneW'((32'(rr_ptr_q) + k) % LANES);
          if (!found && !empty[cand]) begin
            found    = 1'b1;
            pop_lane = cand;
          end
        end
        pop_en = found;
        if (found) rr_ptr_d = lane_inc(pop_lane);
`else
        pop_lane = rr_ptr_q;
        pop_en   = !empty[rr_ptr_q];
        rr_ptr_d = lane_inc(rr_ptr_q);
`endif
        lane_out_d  = pop_lane;
        valid_out_d = pop_en;
        if (pop_en) data_out_d = mem_q[pop_lane][rd_ptr_q[pop_lane]];
        if (&empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    for (int i = 0; i < LANES; i++) begin
      pop_vec[i] = pop_en & (pop_lane == LaneW'(i));
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop_vec[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        count_q[i] <= count_q[i] + CntW'(push[i]) - CntW'(pop_vec[i]);
      end
      overflow_q <= overflow_q | drop;
    end
  end

  // FIFO data storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= data_in[i*WIDTH +: WIDTH];
    end
  end

  // Scheduler state and registered stream outputs
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      lane_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      lane_out_q  <= lane_out_d;
    end
  end

  // Loopback: capture inputs while not active, otherwise hold data, drop valids
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      recirc_data_q  <= '0;
      recirc_valid_q <= '0;
    end else if (!active) begin
      recirc_data_q  <= data_in;
      recirc_valid_q <= valid_in;
    end else begin
      recirc_valid_q <= '0;
    end
  end

  assign overflow     = overflow_q;
  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign lane_out     = lane_out_q;
  assign recirc_data  = recirc_data_q;
  assign recirc_valid = recirc_valid_q;

endmodule

// File: tb/tb_phy_tx_stripe_mux.sv
// Bench for phy_tx_stripe_mux: queue-based reference model updated on every
// clock edge, a per-cycle compare process, and directed scenarios with
// hand-computed expectations followed by a randomized phase.
module tb_phy_tx_stripe_mux;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset_L;
  logic                   active;
  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic [LANES-1:0]       full;
  logic [LANES-1:0]       overflow;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;
  logic [1:0]             lane_out;
  logic [LANES*WIDTH-1:0] recirc_data;
  logic [LANES-1:0]       recirc_valid;

  always #5 clk = ~clk;

  phy_tx_stripe_mux #(
    .LANES(LANES),
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .active      (active),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .full        (full),
    .overflow    (overflow),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .lane_out    (lane_out),
    .recirc_data (recirc_data),
    .recirc_valid(recirc_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0]       mq [LANES][$];
  bit                     m_run;
  int                     m_ptr;
  logic [WIDTH-1:0]       e_data;
  logic                   e_valid;
  logic [1:0]             e_lane;
  logic [LANES-1:0]       e_ovf;
  logic [LANES*WIDTH-1:0] e_rdata;
  logic [LANES-1:0]       e_rvalid;

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) mq[i].delete();
    m_run    = 0;
    m_ptr    = 0;
    e_data   = '0;
    e_valid  = 1'b0;
    e_lane   = '0;
    e_ovf    = '0;
    e_rdata  = '0;
    e_rvalid = '0;
  endtask

  task automatic model_step();
    bit               any_ne;
    bit [LANES-1:0]   was_full;
    int               l;
    any_ne = 0;
    for (int i = 0; i < LANES; i++) begin
      was_full[i] = (mq[i].size() == DEPTH);
      if (mq[i].size() != 0) any_ne = 1;
    end
    e_valid = 1'b0;
    e_data  = '0;
    e_lane  = '0;
    if (!m_run) begin
      m_ptr = 0;
      if (any_ne) m_run = 1;
    end else begin
`ifdef PHY_TX_SKIP_EMPTY_EN
      l = -1;
      for (int k = 0; k < LANES; k++) begin
        int c;
        c = (m_ptr + k) % LANES;
        if (l < 0 && mq[c].size() > 0) l = c;
      end
      if (l >= 0) begin
        e_valid = 1'b1;
        e_data  = mq[l].pop_front();
        e_lane  = 2'(l);
        m_ptr   = (l + 1) % LANES;
      end else begin
        e_lane = 2'(m_ptr);
      end
`else
      l      = m_ptr;
      e_lane = 2'(l);
      if (mq[l].size() > 0) begin
        e_valid = 1'b1;
        e_data  = mq[l].pop_front();
      end
      m_ptr = (m_ptr + 1) % LANES;
`endif
      if (!any_ne) m_run = 0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (active && valid_in[i]) begin
        if (was_full[i]) e_ovf[i] = 1'b1;
        else mq[i].push_back(data_in[i*WIDTH +: WIDTH]);
      end
    end
    if (!active) begin
      e_rdata  = data_in;
      e_rvalid = valid_in;
    end else begin
      e_rvalid = '0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_L);
      if (!reset_L) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      logic [LANES-1:0] exp_full;
      @(negedge clk);
      if (reset_L) begin
        for (int i = 0; i < LANES; i++) exp_full[i] = (mq[i].size() == DEPTH);
        check("valid_out", valid_out, e_valid);
        check("data_out", data_out, e_data);
        check("lane_out", lane_out, e_lane);
        check("full", full, exp_full);
        check("overflow", overflow, e_ovf);
        check("recirc_data", recirc_data, e_rdata);
        check("recirc_valid", recirc_valid, e_rvalid);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] burst [4];
    bit seen;
    burst = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
    reset_L  = 1'b0;
    active   = 1'b1;
    data_in  = '0;
    valid_in = '0;
    repeat (2) tick();
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_lane_out", lane_out, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_recirc_data", recirc_data, 0);
    check("rst_recirc_valid", recirc_valid, 0);
    reset_L = 1'b1;
    repeat (2) tick();

    // One-cycle push on all four lanes
    data_in  = 32'hCCDDEEFF;
    valid_in = 4'hF;
    tick();
    data_in  = '0;
    valid_in = '0;
    tick();
    check("burst_pre_valid", valid_out, 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("burst_valid", valid_out, 1);
      check("burst_data", data_out, burst[j]);
      check("burst_lane", lane_out, j);
    end
    tick();
    check("burst_post_valid", valid_out, 0);
    repeat (3) tick();

    // Single word on lane 2
    data_in  = 32'h0077_0000;
    valid_in = 4'b0100;
    tick();
    data_in  = '0;
    valid_in = '0;
    tick();
    check("l2_pre_valid", valid_out, 0);
`ifndef PHY_TX_SKIP_EMPTY_EN
    tick();
    check("l2_slot0_valid", valid_out, 0);
    check("l2_slot0_lane", lane_out, 0);
    tick();
    check("l2_slot1_valid", valid_out, 0);
    check("l2_slot1_lane", lane_out, 1);
`endif
    tick();
    check("l2_word_valid", valid_out, 1);
    check("l2_word_data", data_out, 8'h77);
    check("l2_word_lane", lane_out, 2);
    repeat (5) tick();

    // Eight back-to-back pushes on lane 1
    for (int v = 1; v <= 8; v++) begin
      data_in  = 32'(v) << 8;
      valid_in = 4'b0010;
      tick();
`ifndef PHY_TX_SKIP_EMPTY_EN
      if (v == 5) check("ovf_full_after_5", full, 4'b0010);
`endif
    end
    data_in  = '0;
    valid_in = '0;
`ifndef PHY_TX_SKIP_EMPTY_EN
    check("ovf_set", overflow, 4'b0010);
`endif
    repeat (24) tick();
`ifndef PHY_TX_SKIP_EMPTY_EN
    check("ovf_sticky", overflow, 4'b0010);
`endif

    // Loopback while not active
    active   = 1'b0;
    data_in  = 32'h8899AABB;
    valid_in = 4'hF;
    tick();
    check("lb_data", recirc_data, 32'h8899AABB);
    check("lb_valid", recirc_valid, 4'hF);
    check("lb_no_tx", valid_out, 0);
    check("lb_no_fill", full, 0);
    active   = 1'b1;
    data_in  = '0;
    valid_in = '0;
    tick();
    check("lb_valid_cleared", recirc_valid, 0);
    check("lb_data_held", recirc_data, 32'h8899AABB);
    tick();
    check("lb_fifo_untouched", valid_out, 0);

    // Reset in the middle of a burst of eight words
    data_in  = $urandom;
    valid_in = 4'hF;
    tick();
    data_in  = $urandom;
    tick();
    data_in  = '0;
    valid_in = '0;
    repeat (2) tick();
    check("pre_rst_busy", valid_out, 1);
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_valid_out", valid_out, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_lane_out", lane_out, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_recirc_data", recirc_data, 0);
    #1 reset_L = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_rst_quiet", valid_out, 0);
    end
    data_in  = 32'h5A00_0000;
    valid_in = 4'b1000;
    tick();
    data_in  = '0;
    valid_in = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (valid_out) seen = 1;
    end
    check("fresh_push_seen", seen, 1);
    check("fresh_push_data", data_out, 8'h5A);
    check("fresh_push_lane", lane_out, 3);
    repeat (6) tick();

    // Randomized traffic with varying load and occasional loopback
    for (int blk = 0; blk < 12; blk++) begin
      int density;
      density = $urandom_range(1, 9);
      for (int c = 0; c < 200; c++) begin
        active  = ($urandom_range(0, 9) != 0);
        data_in = $urandom;
        for (int i = 0; i < LANES; i++) valid_in[i] = ($urandom_range(0, 9) < density);
        tick();
      end
    end
    active   = 1'b1;
    data_in  = '0;
    valid_in = '0;
    repeat (30) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
